// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: owns fetch PC, one outstanding imem read, valid/ready to core
// Optional: define IFU_MISALIGN_CHECK_EN to trap fetch_pc[1]=1 with a nop and a misalign flag.
module ifu_fetch #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
`ifdef IFU_MISALIGN_CHECK_EN
    output logic              misalign,
`endif
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_nxt;
    logic [ADDR_W-1:0] r_inst_pc, w_inst_pc_nxt;
    logic [31:0]       r_inst, w_inst_nxt;
    logic              r_drop, w_drop_nxt;
    logic              r_inst_valid, w_inst_valid_nxt;
    logic [ADDR_W-1:0] w_redir_pc;
    logic [ADDR_W-1:0] w_seq_pc;
    logic              w_gnt;
`ifdef IFU_MISALIGN_CHECK_EN
    logic              r_misalign, w_misalign_nxt;
`endif

    assign w_redir_pc = redirect_pc & ~ADDR_W'(1);
    assign w_seq_pc   = r_fetch_pc + ADDR_W'(4);

`ifdef IFU_MISALIGN_CHECK_EN
    assign imem_req   = (r_state == S_REQ) && !r_fetch_pc[1];
    assign misalign   = r_misalign;
`else
    assign imem_req   = (r_state == S_REQ);
`endif
    assign w_gnt      = imem_req && imem_gnt;
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_drop       <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0;
            r_inst_pc    <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
            r_misalign   <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_drop       <= w_drop_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
`ifdef IFU_MISALIGN_CHECK_EN
            r_misalign   <= w_misalign_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_drop_nxt       = r_drop;
        w_inst_valid_nxt = r_inst_valid;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
`ifdef IFU_MISALIGN_CHECK_EN
        w_misalign_nxt   = r_misalign;
`endif
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (redirect_valid) w_fetch_pc_nxt = w_redir_pc;
            end
            S_REQ: begin
                // A redirect granted in the same cycle leaves a stale response to be dropped.
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redir_pc;
                    if (w_gnt) begin
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
`ifdef IFU_MISALIGN_CHECK_EN
                else if (r_fetch_pc[1]) begin
                    w_state_nxt      = S_HOLD;
                    w_inst_nxt       = 32'h0000_0013;
                    w_inst_pc_nxt    = r_fetch_pc;
                    w_inst_valid_nxt = 1'b1;
                    w_misalign_nxt   = 1'b1;
                end
`endif
                else if (w_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (!r_drop && !redirect_valid) begin
                        w_inst_nxt       = imem_rdata;
                        w_inst_pc_nxt    = r_fetch_pc;
                        w_inst_valid_nxt = 1'b1;
                        w_state_nxt      = S_HOLD;
                    end else begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                        if (redirect_valid) w_fetch_pc_nxt = w_redir_pc;
                    end
                end else if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redir_pc;
                    w_drop_nxt     = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid || inst_ready) begin
                    w_fetch_pc_nxt   = redirect_valid ? w_redir_pc : w_seq_pc;
                    w_inst_valid_nxt = 1'b0;
                    w_state_nxt      = S_REQ;
`ifdef IFU_MISALIGN_CHECK_EN
                    w_misalign_nxt   = 1'b0;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage; sits directly upstream of the single-cycle RV64 core and supplies its 32-bit instruction word.
- Owns the fetch PC and issues one request at a time to an instruction memory port with variable latency.
- Presents each fetched word, with its PC, on a valid/ready interface to the core.
- Accepts branch/jump redirects from the core and discards any stale in-flight response.

Parameters:
ADDR_W, 64, width of fetch PC and memory address
RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
redirect_valid  input  1  core requests fetch from redirect_pc
redirect_pc  input  ADDR_W  redirect target
imem_req  output  1  memory read request
imem_addr  output  ADDR_W  request address, equal to fetch_pc
imem_gnt  input  1  request accepted this cycle when imem_req=1
imem_rvalid  input  1  read data valid; exactly one per granted request
imem_rdata  input  32  instruction word
inst_valid  output  1  inst/inst_pc hold a fetched word
inst  output  32  fetched instruction
inst_pc  output  ADDR_W  address of inst
inst_ready  input  1  core consumes inst this cycle

Behaviour:
- Reset values (async): state=IDLE, fetch_pc=RESET_PC, drop=0, inst_valid=0, inst=32'h0, inst_pc=0, imem_req=0.
- imem_req=1 only in REQ; imem_addr=fetch_pc always. Before gnt, address may change; no stability rule is placed on the memory port.
- IDLE: go to REQ next cycle unconditionally. A redirect in IDLE loads fetch_pc.
- REQ:
  - gnt=1 -> WAIT.
  - redirect without gnt -> fetch_pc<=redirect_pc, stay REQ.
  - redirect with gnt -> fetch_pc<=redirect_pc, drop<=1, go WAIT.
- WAIT:
  - rvalid with drop=0 and no redirect -> inst<=imem_rdata, inst_pc<=fetch_pc, inst_valid<=1, go HOLD.
  - rvalid with drop=1 or redirect -> discard data, drop<=0, go REQ; fetch_pc is updated by any redirect.
  - redirect without rvalid -> fetch_pc<=redirect_pc, drop<=1, stay WAIT.
- HOLD:
  - inst_valid=1, outputs stable until a handshake.
  - inst_ready=1 and no redirect -> fetch_pc<=fetch_pc+4, inst_valid<=0, go REQ.
  - redirect, with or without inst_ready -> fetch_pc<=redirect_pc, inst_valid<=0, go REQ. A same-cycle inst_ready counts as consumed.
- Redirect always has priority over the sequential +4 update.
- Arithmetic: fetch_pc+4 is ADDR_W wide and wraps modulo 2^ADDR_W. Bit 0 of redirect_pc is forced to 0.
- Latency: best case is req+gnt in cycle N, rvalid in N+1, inst_valid in N+2. Peak throughput is 1 instruction per 3 cycles with zero-wait memory and inst_ready held high.
- Reset mid-transaction clears all state. A late rvalid after reset release in IDLE or REQ is ignored.

Optional Feature:
- Macro IFU_MISALIGN_CHECK_EN.
- Enabled:
  - Adds output misalign (1 bit, reset 0).
  - In REQ with fetch_pc[1]=1, no request is issued. The block goes to HOLD with inst=32'h0000_0013 (nop), inst_pc=fetch_pc, inst_valid=1, misalign=1.
  - misalign clears together with inst_valid.
- Disabled: no misalign port; fetch_pc[1:0] is driven to memory unchecked.

Test Plan:
- Reset release, gnt same cycle as req, rvalid next cycle with rdata=32'h00000093, inst_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008 on successive requests; inst_valid pulses every 3rd cycle with inst_pc matching.
- Memory with 5-cycle rvalid latency, inst_ready held 0 for 4 cycles in HOLD -> inst/inst_pc stable for all 4 cycles; exactly one request outstanding; next imem_addr=inst_pc+4.
- Redirect to 0x80000100 in WAIT, before rvalid -> returned word not presented; next imem_addr=0x80000100; inst_pc=0x80000100 on the next inst_valid.
- Redirect in HOLD with inst_ready=1 in the same cycle -> inst_valid drops next cycle; next imem_addr=redirect_pc, not inst_pc+4.
- Assert rst while in WAIT, then deliver rvalid after release -> response ignored; first post-reset request address=RESET_PC; inst_valid stays 0 until that response.
- IFU_MISALIGN_CHECK_EN defined, redirect to 0x80000002 -> imem_req stays 0 for that address; inst_valid=1, misalign=1, inst=32'h00000013, inst_pc=0x80000002.
